// File: rtl/uart_mem_ctrl.sv
// Sequencer between UART rx/tx and a single-port byte RAM: stores 2*BYTE_LENGTH received
// bytes, then replays the upper half to the transmitter one byte per tx handshake.
module uart_mem_ctrl #(
    parameter int BYTE_LENGTH = 128,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem2uart,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              recv_done,
    output logic              send_done,
    output logic              rx_overflow
);

    typedef enum logic [2:0] {RECV, HOLD, RD, LOAD, START, ACK, BUSY, DONE} state_t;

    localparam logic [ADDR_W:0]   LAST_WR = (ADDR_W+1)'(2*BYTE_LENGTH-1);
    localparam logic [ADDR_W-1:0] LAST_RD = ADDR_W'(BYTE_LENGTH-1);
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BYTE_LENGTH);

    state_t            state;
    logic [ADDR_W:0]   wr_cnt;
    logic [ADDR_W-1:0] rd_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q;
    logic              wr_en;

    // Receive writes go straight through so the byte lands in the cycle rx_valid pulses.
    assign wr_en     = !rst && rx_valid && (state == RECV);
    assign mem_we    = wr_en;
    assign mem_addr  = wr_en ? wr_cnt[ADDR_W-1:0] : addr_q;
    assign mem_wdata = wr_en ? rx_data : wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RECV;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            recv_done   <= 1'b0;
            send_done   <= 1'b0;
            rx_overflow <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            if (rx_valid && (state != RECV))
                rx_overflow <= 1'b1;
            case (state)
                RECV: if (rx_valid) begin
                    addr_q  <= wr_cnt[ADDR_W-1:0];
                    wdata_q <= rx_data;
                    wr_cnt  <= wr_cnt + 1'b1;
                    if (wr_cnt == LAST_WR) begin
                        state     <= HOLD;
                        recv_done <= 1'b1;
                    end
                end
                // Address is registered on entry to RD so the RAM sees it during RD.
                HOLD: if (mem2uart && recv_done) begin
                    rd_cnt <= '0;
                    addr_q <= BASE;
                    state  <= RD;
                end
                RD:   state <= LOAD;
                LOAD: begin
                    tx_data  <= mem_rdata;
                    tx_start <= 1'b1;
                    state    <= START;
                end
                START: state <= ACK;
                ACK:   if (tx_busy) state <= BUSY;
                BUSY: if (!tx_busy) begin
                    if (rd_cnt == LAST_RD) begin
                        state     <= DONE;
                        send_done <= 1'b1;
                    end else begin
                        rd_cnt <= rd_cnt + 1'b1;
                        addr_q <= BASE + rd_cnt + 1'b1;
                        state  <= RD;
                    end
                end
                DONE:    state <= DONE;
                default: state <= RECV;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mem_ctrl.sv
// Scoreboard bench for uart_mem_ctrl: expected writes and transmitted bytes are queued from
// the stimulus; a negedge monitor pops and compares whenever the DUT writes or starts a byte.
module tb_uart_mem_ctrl;
    localparam int BL = 128;
    localparam int AW = 8;
    localparam int N  = 2*BL;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem2uart = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          tx_busy = 1'b0;
    logic [7:0]    mem_rdata;
    logic          tx_start, mem_we, recv_done, send_done, rx_overflow;
    logic [7:0]    tx_data, mem_wdata;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    uart_mem_ctrl #(.BYTE_LENGTH(BL), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .mem2uart(mem2uart), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .recv_done(recv_done), .send_done(send_done), .rx_overflow(rx_overflow)
    );

    // Registered single-port RAM attached to the controller.
    logic [7:0] ram [0:255];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not expected (t=%0t)", name, $time);
    endtask

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        wq[$];
    logic [7:0] txq[$];
    int         tx_seen = 0;
    int         last_busy_cyc = 0;
    int         rd_rise_cyc = 0;
    bit         first_in_send = 1'b0;
    bit         early_mode = 1'b0;
    logic       prev_rd = 1'b0;

    // Monitor: every write and every tx_start must match the head of its queue.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (wq.size() == 0) fail_now("unexpected_write");
            else begin
                wr_t w;
                w = wq.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(w.a));
                chk("wr_data", 32'(mem_wdata), 32'(w.d));
                chk("recv_done_before_last_write", 32'(recv_done), 0);
            end
        end
        if (recv_done === 1'b1 && prev_rd !== 1'b1) rd_rise_cyc = cyc;
        prev_rd = recv_done;
        if (tx_start === 1'b1) begin
            tx_seen++;
            if (txq.size() == 0) fail_now("unexpected_tx_start");
            else chk("tx_data", 32'(tx_data), 32'(txq.pop_front()));
            if (first_in_send) begin
                if (early_mode) chk("first_start_latency", 32'(cyc - rd_rise_cyc), 3);
                first_in_send = 1'b0;
            end else begin
                chk("busy_fall_to_start", 32'(cyc - last_busy_cyc), 4);
            end
        end
        if (tx_busy) last_busy_cyc = cyc;
    end

    // Transmitter model: busy rises the cycle after tx_start is sampled, held 50 cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (50) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_zero(input string tag);
        chk({tag, "_tx_start"},    32'(tx_start), 0);
        chk({tag, "_tx_data"},     32'(tx_data), 0);
        chk({tag, "_mem_we"},      32'(mem_we), 0);
        chk({tag, "_mem_addr"},    32'(mem_addr), 0);
        chk({tag, "_mem_wdata"},   32'(mem_wdata), 0);
        chk({tag, "_recv_done"},   32'(recv_done), 0);
        chk({tag, "_send_done"},   32'(send_done), 0);
        chk({tag, "_rx_overflow"}, 32'(rx_overflow), 0);
    endtask

    task automatic do_reset(input int n, input bit noisy);
        @(posedge clk);
        #1 rst = 1'b1;
        wq.delete();
        txq.delete();
        if (noisy) begin
            rx_valid = 1'b1;
            rx_data  = 8'h3C;
            mem2uart = 1'b1;
        end
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            check_zero("reset");
        end
        rst      = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] d);
        @(posedge clk);
        #1 rx_valid = 1'b1;
        rx_data = d;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    // mode 0: data i^A5 every 10 cycles; mode 1: random data and spacing.
    task automatic fill(input int mode);
        logic [7:0] sent [N];
        for (int i = 0; i < N; i++) begin
            sent[i] = (mode == 0) ? (8'(i) ^ 8'hA5) : 8'($urandom);
            wq.push_back({8'(i), sent[i]});
        end
        for (int i = 0; i < BL; i++) txq.push_back(sent[BL + i]);
        for (int i = 0; i < N; i++) begin
            pulse(sent[i]);
            if (i != N-1) repeat ((mode == 0) ? 8 : $urandom_range(0, 3)) @(posedge clk);
        end
        @(negedge clk);
        chk("recv_done_after_last_write", 32'(recv_done), 1);
        chk("writes_outstanding", 32'(wq.size()), 0);
        chk("overflow_during_fill", 32'(rx_overflow), 0);
    endtask

    task automatic wait_tx(input int n);
        int k = 0;
        while (tx_seen < n && k < 20000) begin
            @(negedge clk);
            k++;
        end
        chk("tx_count_reached", 32'(tx_seen >= n), 1);
    endtask

    task automatic finish_send(input int base);
        int k = 0;
        wait_tx(base + BL);
        while (tx_busy !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        k = 0;
        while (tx_busy !== 1'b0 && k < 200) begin @(negedge clk); k++; end
        chk("last_busy_fall", 32'(tx_busy), 0);
        chk("send_done_before_last_fall", 32'(send_done), 0);
        repeat (2) @(negedge clk);
        chk("send_done_after_last_fall", 32'(send_done), 1);
        repeat (300) @(negedge clk);
        chk("tx_total", 32'(tx_seen - base), BL);
        chk("tx_expected_left", 32'(txq.size()), 0);
        chk("send_done_sticky", 32'(send_done), 1);
    endtask

    initial begin
        int base;
        int k;

        // Run A: noisy reset, early request, overflow pulses during the send.
        do_reset(3, 1'b1);
        mem2uart      = 1'b1;
        early_mode    = 1'b1;
        first_in_send = 1'b1;
        base          = tx_seen;
        fill(0);
        wait_tx(base + 5);
        for (int i = 0; i < 3; i++) begin
            pulse(8'($urandom));
            repeat (7) @(posedge clk);
        end
        @(negedge clk);
        chk("overflow_during_send", 32'(rx_overflow), 1);
        finish_send(base);

        // Run B: request only after HOLD, overflow in HOLD, reset in the middle of byte 40.
        mem2uart = 1'b0;
        do_reset(2, 1'b0);
        early_mode    = 1'b0;
        first_in_send = 1'b1;
        base          = tx_seen;
        fill(1);
        repeat (5) @(posedge clk);
        for (int i = 0; i < 2; i++) pulse(8'($urandom));
        @(negedge clk);
        chk("no_send_without_request", 32'(tx_seen - base), 0);
        chk("overflow_in_hold", 32'(rx_overflow), 1);
        @(posedge clk);
        #1 mem2uart = 1'b1;
        wait_tx(base + 1);
        mem2uart = 1'b0;
        wait_tx(base + 40);
        k = 0;
        while (tx_busy !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        txq.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_zero("midsend_reset");
        repeat (80) @(negedge clk);
        chk("no_tx_after_reset", 32'(tx_seen - base), 40);

        // Run C: refill new data and replay it completely.
        first_in_send = 1'b1;
        base          = tx_seen;
        fill(1);
        @(posedge clk);
        #1 mem2uart = 1'b1;
        finish_send(base);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_mem_ctrl.md
Name: uart_mem_ctrl

Overview:
- Sequencer for the UART loopback memory datapath: owns the address counters and state for a single-port byte RAM between a UART receiver and a UART transmitter.
- Receive phase: writes 2*BYTE_LENGTH received bytes into RAM in arrival order.
- Send phase: on mem2uart, replays the upper half (addresses BYTE_LENGTH..2*BYTE_LENGTH-1) to the transmitter, one byte per tx handshake.
- Reports recv_done and send_done to the top level.

Parameters:
- BYTE_LENGTH, 128: bytes per half; receive count is 2*BYTE_LENGTH, send count is BYTE_LENGTH.
- ADDR_W, 8: RAM address width; must satisfy 2^ADDR_W >= 2*BYTE_LENGTH.

Ports:
- clk  in  1  system clock (100 MHz); single clock domain.
- rst  in  1  reset; synchronous, active-high.
- mem2uart  in  1  level request to start the send phase.
- rx_valid  in  1  one-cycle pulse: rx_data holds a complete received byte.
- rx_data  in  8  received byte.
- tx_start  out  1  one-cycle pulse: transmitter loads tx_data.
- tx_data  out  8  byte to transmit; stable from tx_start until tx_busy falls.
- tx_busy  in  1  transmitter busy; rises the cycle after tx_start is sampled, falls after the stop bit.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  8  RAM write data.
- mem_rdata  in  8  RAM read data; registered, valid 1 cycle after the address is presented.
- recv_done  out  1  all 2*BYTE_LENGTH bytes stored; sticky until rst.
- send_done  out  1  all BYTE_LENGTH bytes transmitted; sticky until rst.
- rx_overflow  out  1  sticky; an rx_valid arrived outside the RECV state.

Behaviour:
- Reset (rst=1 at a clk edge): state=RECV, wr_cnt=0, rd_cnt=0.
  - All outputs 0: tx_start, tx_data, mem_we, mem_addr, mem_wdata, recv_done, send_done, rx_overflow.
  - RAM contents are not cleared.
  - Reset mid-operation aborts any phase immediately. tx_start is never issued on the reset cycle.
- RECV:
  - On rx_valid: same cycle, mem_we=1, mem_addr=wr_cnt, mem_wdata=rx_data. Next cycle wr_cnt increments.
  - mem_we is a one-cycle pulse per byte; rx_valid absent means mem_we=0.
  - The write at wr_cnt=2*BYTE_LENGTH-1 moves to HOLD and sets recv_done the next cycle.
- HOLD:
  - Waits for mem2uart=1, sampled while recv_done=1.
  - A mem2uart asserted earlier (during RECV) is honoured on the first HOLD cycle.
  - Transition sets rd_cnt=0 and goes to RD.
- RD: mem_addr=BYTE_LENGTH+rd_cnt, mem_we=0; go to LOAD.
- LOAD: latch mem_rdata into tx_data; go to START.
- START: tx_start=1 for exactly one cycle; go to ACK.
- ACK: wait for tx_busy=1, then go to BUSY.
  - No timeout; a stuck transmitter hangs here until rst.
- BUSY: wait for tx_busy=0.
  - If rd_cnt=BYTE_LENGTH-1: go to DONE.
  - Otherwise rd_cnt++ and go to RD.
- DONE: send_done=1 from the cycle after entry; stays in DONE until rst. mem2uart is ignored.
- Per-byte overhead: 4 cycles from tx_busy fall to the next tx_start (BUSY→RD→LOAD→START).
- mem2uart deasserted mid-send does not stop the send phase; it is only sampled in HOLD.
- rx_valid in any state other than RECV: no write, rx_overflow set (sticky).
- rx_valid on the same cycle as rst: ignored.
- Counter widths:
  - wr_cnt is ADDR_W+1 bits, so the 2*BYTE_LENGTH count never aliases.
  - rd_cnt is ADDR_W bits; it never wraps because sending stops at BYTE_LENGTH-1.
- mem_addr holds its last value when mem_we=0 outside RD.
- Outputs are registered except mem_we, mem_addr and mem_wdata in RECV, which are combinational from rx_valid/rx_data.

Test Plan:
- Reset values: hold rst 3 cycles with rx_valid=1 and mem2uart=1 → all outputs 0, no mem_we, state RECV after release.
- Receive fill: 256 rx_valid pulses, data=i^8'hA5, spaced 10 cycles → 256 mem_we pulses at addr 0..255 with matching data; recv_done=1 exactly one cycle after the 256th write, not before.
- Early request: mem2uart=1 from reset through the fill → first tx_start 3 cycles after recv_done rises; tx_data = RAM[128].
- Send sequence: tx model with busy=1 for 50 cycles after each start → 128 tx_start pulses carrying RAM[128..255] in order, 4 cycles from each busy fall to the next start; send_done=1 after the 128th busy fall; no further tx_start.
- Overflow and ignore: rx_valid pulses in HOLD and during send → no mem_we, rx_overflow=1, transmitted bytes unchanged.
- Mid-send reset: rst during byte 40's busy → all outputs 0 next cycle; refill 256 new bytes and resend → full correct 128-byte replay of the new data.
